deserializador: RTL

- Serial-to-parallel stage placed directly downstream of the 8-bit serializer in the serdes path.
- Samples the serial bit stream `in` with its per-bit valid flag `DK`, one bit per clock, MSB first.
- Reassembles BITS-bit words and presents each completed word on `data` with a one-cycle `valid` pulse.
- Detects words truncated by a drop of `DK` and counts completed words.

---
 rtl/deserializador.sv | 68 ++++++
 1 files changed

// File: rtl/deserializador.sv
// Serial-to-parallel word assembler: samples one MSB-first bit per clock while DK is high,
// emits each completed BITS-bit word with a one-cycle valid pulse, flags truncated words on err.
module deserializador #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in,
    input  logic            DK,
    output logic [BITS-1:0] data,
    output logic            valid,
    output logic            err,
    output logic            busy,
    output logic [7:0]      word_cnt
);

    localparam int CW = $clog2(BITS) + 1;
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]      state;
    logic [BITS-1:0] shreg;
    logic [CW-1:0]   cnt;

    assign busy = (state == SHIFT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            data     <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
            word_cnt <= '0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (state == IDLE) begin
                // First bit of a word lands in the LSB and walks up to the MSB as the rest arrive
                if (DK) begin
                    shreg <= {{(BITS-1){1'b0}}, in};
                    cnt   <= CW'(1);
                    state <= SHIFT;
                end
            end else begin
                if (!DK) begin
                    err   <= 1'b1;
                    shreg <= '0;
                    cnt   <= '0;
                    state <= IDLE;
                end else if (cnt == LAST) begin
                    data     <= {shreg[BITS-2:0], in};
                    valid    <= 1'b1;
                    word_cnt <= word_cnt + 8'd1;
                    cnt      <= '0;
                    state    <= IDLE;
                end else begin
                    shreg <= {shreg[BITS-2:0], in};
                    cnt   <= cnt + CW'(1);
                end
            end
        end
    end

endmodule
